// File: rtl/fgp_ram_writer_pkg.sv
// fgp_ram_writer_pkg: FGP packet geometry and writer state encodings
package fgp_ram_writer_pkg;
  localparam int FGP_OFFSET_LEN     = 1;
  localparam int FGP_DATA_LEN       = 768;
  localparam int FGP_PIXELS_PER_PKT = 512;
  localparam int FGP_COLOR_WIDTH    = 12;
  typedef enum logic {S_IDLE, S_DATA} state_t;
endpackage

// File: rtl/fgp_byte_unpack.sv
// fgp_byte_unpack: turns a byte stream into 12-bit colours, two per 3-byte triple, big-endian
module fgp_byte_unpack
  import fgp_ram_writer_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clr,
  input  logic                       i_valid,
  input  logic [7:0]                 i_byte,
  output logic                       o_valid,
  output logic [FGP_COLOR_WIDTH-1:0] o_color
);
  logic [1:0] r_phase;
  logic [7:0] r_b0;
  logic [3:0] r_nib;
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_phase <= '0;
      r_b0    <= '0;
      r_nib   <= '0;
    end else if (i_valid) begin
      r_phase <= (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;
      if (r_phase == 2'd0) r_b0 <= i_byte;
      if (r_phase == 2'd1) r_nib <= i_byte[3:0];
    end
  end
  assign o_valid = i_valid && (r_phase != 2'd0);
  assign o_color = (r_phase == 2'd1) ? {r_b0, i_byte[7:4]} : {r_nib, i_byte};
endmodule

// File: rtl/fgp_ram_writer.sv
// fgp_ram_writer: writes unpacked FGP packet colours to RAM at offset*512 + pixel index,
// flagging packet completion and sticky protocol errors.
module fgp_ram_writer
  import fgp_ram_writer_pkg::*;
#(
  parameter int ADDR_WIDTH     = 17,
  parameter int PIXELS_PER_PKT = FGP_PIXELS_PER_PKT,
  parameter int COLOR_WIDTH    = FGP_COLOR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   offset_inclk,
  input  logic [7:0]             offset_in,
  input  logic                   inclk,
  input  logic [7:0]             in,
  input  logic                   pkt_end,
  output logic                   ram_we,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  output logic [COLOR_WIDTH-1:0] ram_data,
  output logic                   pkt_done,
  output logic                   err
);
  localparam int PW = $clog2(PIXELS_PER_PKT);
  localparam int CW = $clog2(PIXELS_PER_PKT * 3 / 2);
  localparam logic [CW-1:0] LAST_BYTE = CW'(PIXELS_PER_PKT * 3 / 2 - 1);
  state_t                r_state, w_next;
  logic [8+PW-1:0]       r_base;
  logic [PW-1:0]         r_pix;
  logic [CW-1:0]         r_cnt;
  logic                  r_we, r_done, r_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [COLOR_WIDTH-1:0] r_data;
  logic                  w_acc, w_last, w_end, w_err, w_val;
  logic [FGP_COLOR_WIDTH-1:0] w_color;
  logic [ADDR_WIDTH:0]   w_sum;
  // a new offset always wins: the byte beside it is dropped
  assign w_acc  = (r_state == S_DATA) && inclk && !offset_inclk;
  assign w_last = w_acc && (r_cnt == LAST_BYTE);
  assign w_end  = w_last || ((r_state == S_DATA) && pkt_end && !offset_inclk);
  assign w_err  = (inclk && !offset_inclk && (r_state == S_IDLE))
               || (offset_inclk && (r_state == S_DATA))
               || (w_end && !w_last);
  assign w_sum  = (ADDR_WIDTH+1)'(r_base) + (ADDR_WIDTH+1)'(r_pix);
  always_comb w_next = offset_inclk ? S_DATA : (w_end ? S_IDLE : r_state);
  fgp_byte_unpack u_unpack (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (offset_inclk || w_end),
    .i_valid (w_acc),
    .i_byte  (in),
    .o_valid (w_val),
    .o_color (w_color)
  );
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base <= '0;
      r_pix  <= '0;
      r_cnt  <= '0;
      r_we   <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we   <= w_val;
      r_done <= w_last;
      if (w_err) r_err <= 1'b1;
      if (w_val) begin
        r_addr <= w_sum[ADDR_WIDTH-1:0];
        r_data <= COLOR_WIDTH'(w_color);
      end
      if (offset_inclk) begin
        r_base <= {offset_in, PW'(0)};
        r_pix  <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_acc) r_cnt <= r_cnt + 1'b1;
        if (w_val) r_pix <= r_pix + 1'b1;
      end
    end
  end
  // outputs read as zero while rst is held, hiding a write registered just before it
  assign ram_we   = r_we && !rst;
  assign pkt_done = r_done && !rst;
  assign err      = r_err && !rst;
  assign ram_addr = rst ? '0 : r_addr;
  assign ram_data = rst ? '0 : r_data;
endmodule
